stack_drain: RTL and testbench
==============================

# stack_drain

Burst-drain controller sitting directly downstream of the team's LIFO stack. On a command it pops up to a requested number of entries from the stack, captures each top-of-stack value into a 2-entry output buffer, and presents them on a valid/ready stream. It reports completion with the number of entries actually drained. A burst ends early if the stack runs empty.

## Interface
- DATA_WIDTH, 8, width of stack entries and output data
- CNT_WIDTH, 5, width of burst count; max burst 2^CNT_WIDTH-1
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  burst command valid
- req_ready  out  1  command accepted when high with req_valid; high only in IDLE
- req_count  in  CNT_WIDTH  number of entries to drain
- stk_head  in  DATA_WIDTH  stack top-of-stack value, combinational from stack
- stk_empty  in  1  stack empty flag
- stk_insert  in  1  copy of the stack's insert line; the stack ignores pop while insert is high
- stk_pop  out  1  pop request to stack, combinational
- out_data  out  DATA_WIDTH  buffer head data
- out_valid  out  1  buffer non-empty
- out_ready  in  1  downstream accept
- out_last  out  1  final beat of burst; present only with STACK_DRAIN_LAST_EN
- done  out  1  one-cycle pulse at burst end
- done_count  out  CNT_WIDTH  entries drained in the finished burst; held until next done
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, DRAIN, FLUSH, DONE.
- IDLE: req_ready=1. On req_valid, latch remaining=req_count, clear drained, go to DRAIN. If req_count==0, go straight to DONE.
- DRAIN: pop_ok = ~stk_empty & ~stk_insert & (occ<2 | out handshake this cycle). stk_pop=pop_ok, with no other gating. On a pop_ok cycle, write stk_head into the buffer, decrement remaining, and increment drained.
- DRAIN exit: go to FLUSH when remaining reaches 0 after a pop, or when stk_empty is sampled high (early end; the pop is not issued that cycle).
- stk_insert high: stall, with no pop and no count change. This is not an early end.
- FLUSH: no pops. Go to DONE when occ==0, including via a handshake in the same cycle.
- DONE: done=1 for one cycle, done_count<=drained. Return to IDLE.
- Buffer: 2-entry FIFO, first-in first-out. Simultaneous write and read is allowed at any occupancy (0 to 2).
- Counts are unsigned CNT_WIDTH. remaining never underflows. drained ≤ req_count.

## Timing
- Reset values: state IDLE, req_ready=1, stk_pop=0, out_valid=0, out_data=0, out_last=0, done=0, done_count=0, busy=0, occ=0.
- Command accepted at edge N; first stk_pop possible in cycle N+1.
- stk_pop in cycle k means data is visible on out_data/out_valid in cycle k+1, a latency of 1.
- Sustained throughput is 1 entry/cycle while out_ready=1 and the stack is non-empty.
- out_valid/out_data hold stable while out_ready=0.
- done asserts the cycle after the last buffer entry is accepted. busy drops the cycle after done.
- Reset mid-burst aborts immediately: buffered data is discarded and no done is produced.

## Configuration
- STACK_DRAIN_LAST_EN defined: out_last port exists. It asserts alongside out_valid on the final buffered entry of the burst, whether the burst ended by count or by early empty. Each buffer slot carries a last bit.
- Undefined: no out_last port and no last bits. All other behaviour is identical.

## Test plan
- Stack holds 5 entries {A,B,C,D,E}, E on top; req_count=3, out_ready=1 -> stk_pop high 3 consecutive cycles; out stream E,D,C; done with done_count=3; stack left with 2 entries.
- Stack holds 2 entries; req_count=6 -> 2 pops, stk_empty ends DRAIN; done_count=2; out_last on the second beat (macro on).
- req_count=0 -> no pops; done the cycle after acceptance with done_count=0.
- req_count=4, out_ready low for 5 cycles -> exactly 2 pops then stall with out_data held; on release, remaining 2 pops resume; output order is preserved.
- stk_insert held high 3 cycles mid-burst -> stk_pop=0 for those cycles; remaining unchanged; burst completes with the full count.
- rst_n low during DRAIN with occ=2 -> out_valid=0, busy=0, req_ready=1 immediately; no done pulse.

Source files
------------

// File: rtl/stack_drain.sv
// Burst-drain controller: pops up to req_count entries off the LIFO stack into a 2-entry FIFO
// and streams them out. Optional out_last port is enabled by defining STACK_DRAIN_LAST_EN.
module stack_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [CNT_WIDTH-1:0]  req_count,
    input  logic [DATA_WIDTH-1:0] stk_head,
    input  logic                  stk_empty,
    input  logic                  stk_insert,
    output logic                  stk_pop,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
`ifdef STACK_DRAIN_LAST_EN
    output logic                  out_last,
`endif
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  done_count,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, DONE} state_t;

    state_t                state;
    logic [CNT_WIDTH-1:0]  remaining;
    logic [CNT_WIDTH-1:0]  drained;
    logic [DATA_WIDTH-1:0] mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            occ;
    logic                  rd_fire;
    logic                  pop_ok;

    assign out_valid = (occ != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign rd_fire   = out_valid & out_ready;
    // A full buffer can still accept a pop when its head leaves in the same cycle.
    assign pop_ok    = (state == DRAIN) & ~stk_empty & ~stk_insert & ((occ != 2'd2) | rd_fire);
    assign stk_pop   = pop_ok;
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            remaining  <= '0;
            drained    <= '0;
            done       <= 1'b0;
            done_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        remaining <= req_count;
                        drained   <= '0;
                        if (req_count == '0) begin
                            state      <= DONE;
                            done       <= 1'b1;
                            done_count <= '0;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (stk_empty) begin
                        state <= FLUSH;
                    end else if (pop_ok) begin
                        remaining <= remaining - CNT_WIDTH'(1);
                        drained   <= drained + CNT_WIDTH'(1);
                        if (remaining == CNT_WIDTH'(1))
                            state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if ((occ == 2'd0) || ((occ == 2'd1) && rd_fire)) begin
                        state      <= DONE;
                        done       <= 1'b1;
                        done_count <= drained;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (pop_ok) begin
                mem[wr_ptr] <= stk_head;
                wr_ptr      <= ~wr_ptr;
            end
            if (rd_fire)
                rd_ptr <= ~rd_ptr;
            occ <= occ + {1'b0, pop_ok} - {1'b0, rd_fire};
        end
    end

`ifdef STACK_DRAIN_LAST_EN
    logic last_q [2];
    logic early_end;

    // An early end is only discovered after the final pop, so the newest entry is tagged late;
    // if it is alone in the buffer it is flagged combinationally so it is never sent untagged.
    assign early_end = (state == DRAIN) & stk_empty;
    assign out_last  = out_valid & (last_q[rd_ptr] | (early_end & (occ == 2'd1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q[0] <= 1'b0;
            last_q[1] <= 1'b0;
        end else if (pop_ok) begin
            last_q[wr_ptr] <= (remaining == CNT_WIDTH'(1));
        end else if (early_end && occ != 2'd0) begin
            last_q[~wr_ptr] <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_stack_drain.sv
// Randomized scoreboard bench for stack_drain with a queue-based LIFO stack model.
`timescale 1ns/1ps
module tb_stack_drain;
    localparam int DW = 8;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [CW-1:0] req_count = '0;
    logic [DW-1:0] stk_head = '0;
    logic          stk_empty = 1'b1;
    logic          stk_insert = 1'b0;
    logic          stk_pop;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
`ifdef STACK_DRAIN_LAST_EN
    logic          out_last;
`endif
    logic          done;
    logic [CW-1:0] done_count;
    logic          busy;

    stack_drain #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_count(req_count),
        .stk_head(stk_head), .stk_empty(stk_empty), .stk_insert(stk_insert), .stk_pop(stk_pop),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
`ifdef STACK_DRAIN_LAST_EN
        .out_last(out_last),
`endif
        .done(done), .done_count(done_count), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] stk[$];
    logic [DW-1:0] exp_data[$];
    bit            exp_last[$];
    int            exp_done[$];
    int  exp_n, acc_cyc, done_cyc, pops_burst, first_pop, last_pop;
    int  done_seen = 0;
    int  ready_mode = 1, ins_mode = 1;
    bit  mon_en = 0;
    bit  hold_v = 0;
    logic [DW-1:0] hold_d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic fail(input string name, input string msg);
        checks++;
        errors++;
        $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
    endtask

    // Monitor: pops expected beats/completions whenever the DUT presents them.
    always @(negedge clk) begin
        if (mon_en) begin
            if (hold_v) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, hold_d);
            end
            hold_v = out_valid && !out_ready;
            hold_d = out_data;
            if (out_valid && out_ready) begin
                if (exp_data.size() == 0) fail("unexpected_beat", "no beat expected");
                else begin
                    logic [DW-1:0] d;
                    bit l;
                    d = exp_data.pop_front();
                    l = exp_last.pop_front();
                    chk("out_data", out_data, d);
`ifdef STACK_DRAIN_LAST_EN
                    chk("out_last", out_last, l);
`endif
                end
            end
            if (done) begin
                done_cyc = cyc;
                done_seen++;
                if (exp_done.size() == 0) fail("unexpected_done", "no done expected");
                else chk("done_count", done_count, exp_done.pop_front());
            end
        end
    end

    task automatic drive();
        stk_head  = (stk.size() > 0) ? stk[$] : '0;
        stk_empty = (stk.size() == 0);
        case (ready_mode)
            0:       out_ready = ($urandom_range(0, 9) < 7);
            1:       out_ready = 1'b1;
            default: out_ready = 1'b0;
        endcase
        case (ins_mode)
            0:       stk_insert = ($urandom_range(0, 9) < 2);
            1:       stk_insert = 1'b0;
            default: stk_insert = 1'b1;
        endcase
    endtask

    task automatic step();
        bit pop_now, acc_now;
        @(negedge clk);
        pop_now = stk_pop;
        acc_now = req_valid && req_ready;
        if (stk_pop) begin
            chk("pop_legal", {30'd0, stk_insert, stk_empty}, 0);
            pops_burst++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
        end
        if (acc_now) begin
            int sz;
            sz    = stk.size();
            exp_n = (int'(req_count) < sz) ? int'(req_count) : sz;
            for (int i = 0; i < exp_n; i++) begin
                exp_data.push_back(stk[sz-1-i]);
                exp_last.push_back(i == exp_n - 1);
            end
            exp_done.push_back(exp_n);
            acc_cyc    = cyc;
            pops_burst = 0;
            first_pop  = -1;
        end
        @(posedge clk);
        #1;
        if (pop_now && stk.size() > 0) void'(stk.pop_back());
        if (acc_now) req_valid = 1'b0;
        drive();
    endtask

    task automatic fill(input int depth);
        stk.delete();
        for (int i = 0; i < depth; i++) stk.push_back(DW'($urandom));
        drive();
    endtask

    task automatic issue(input int cnt);
        req_count = CW'(cnt);
        req_valid = 1'b1;
    endtask

    task automatic wait_done();
        int d0, k;
        d0 = done_seen;
        k  = 0;
        while (done_seen == d0 && k < 400) begin
            step();
            k++;
        end
        if (done_seen == d0) fail("done_timeout", "no done within 400 cycles");
        chk("busy_after_done", busy, 0);
        chk("ready_after_done", req_ready, 1);
        chk("pops_in_burst", pops_burst, exp_n);
        chk("beats_left", exp_data.size(), 0);
    endtask

    initial begin
        int p0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_stk_pop", stk_pop, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_done", done, 0);
        chk("rst_done_count", done_count, 0);
        chk("rst_busy", busy, 0);
`ifdef STACK_DRAIN_LAST_EN
        chk("rst_out_last", out_last, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1;

        // Five entries, E on top, drain three with a free-flowing sink.
        stk.delete();
        for (int i = 0; i < 5; i++) stk.push_back(DW'(8'hA1 + i));
        ready_mode = 1; ins_mode = 1; drive();
        issue(3); wait_done();
        chk("t1_consecutive_pops", last_pop - first_pop + 1, 3);
        chk("t1_stack_left", stk.size(), 2);

        // Early end: two entries, six requested.
        fill(2); issue(6); wait_done();

        // Zero-length burst completes the cycle after acceptance.
        fill(3); issue(0); wait_done();
        chk("t3_done_latency", done_cyc - acc_cyc, 1);

        // Backpressure: sink stalled five cycles after acceptance.
        ready_mode = 2; fill(6); issue(4);
        for (int i = 0; i < 6; i++) step();
        chk("t4_pops_during_stall", pops_burst, 2);
        ready_mode = 1; drive();
        wait_done();

        // Insert held three cycles mid-burst.
        ready_mode = 1; fill(7); issue(5);
        step(); step(); step();
        ins_mode = 2; stk_insert = 1'b1;
        p0 = pops_burst;
        step(); step();
        ins_mode = 1;
        step();
        chk("t5_no_pop_on_insert", pops_burst, p0);
        wait_done();

        // Reset mid-burst with a full buffer.
        ready_mode = 2; fill(6); issue(4);
        for (int i = 0; i < 4; i++) step();
        chk("t6_occ_full_valid", out_valid, 1);
        mon_en = 0; hold_v = 0;
        rst_n = 1'b0;
        #1;
        chk("t6_valid_after_rst", out_valid, 0);
        chk("t6_busy_after_rst", busy, 0);
        chk("t6_ready_after_rst", req_ready, 1);
        chk("t6_pop_after_rst", stk_pop, 0);
        exp_data.delete(); exp_last.delete(); exp_done.delete();
        mon_en = 1;
        step(); step();
        @(negedge clk) rst_n = 1'b1;
        ready_mode = 0; ins_mode = 0;
        step(); step();

        // Randomized bursts with random backpressure and insert stalls.
        for (int t = 0; t < 30; t++) begin
            fill((t % 7 == 6) ? $urandom_range(28, 36) : $urandom_range(0, 9));
            issue((t % 10 == 9) ? 31 : $urandom_range(0, 12));
            wait_done();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
